text_layer: RTL and testbench

TEXT_LAYER -- requirements
Module: text_layer

---
 rtl/text_layer_pkg.sv | 40 ++++
 rtl/text_layer_font_rom.sv | 33 +++
 rtl/text_layer.sv | 198 +++++++++++++++++++
 tb/tb_text_layer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/text_layer_pkg.sv
// Shared definitions for the text layer: CPU register offsets above the two
// RAMs, the attribute nibble layout, CPU address decode selector and scroll wrap.
package text_pkg;

  // Register offsets relative to 2N (the end of attr RAM)
  localparam int unsigned OFS_SCROLL_X   = 0;
  localparam int unsigned OFS_SCROLL_Y   = 1;
  localparam int unsigned OFS_CURSOR_COL = 2;
  localparam int unsigned OFS_CURSOR_ROW = 3;

  // attr[7:4] is the background colour, attr[3:0] the foreground colour
  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
  } attr_t;

  typedef enum logic [2:0] {
    SEL_CHAR,
    SEL_ATTR,
    SEL_SCROLL_X,
    SEL_SCROLL_Y,
    SEL_CURSOR_COL,
    SEL_CURSOR_ROW,
    SEL_NONE
  } sel_t;

  // (pos + offs) mod lim; offs is first reduced by one conditional subtract,
  // then the 9-bit sum gets one more conditional subtract.
  function automatic logic [7:0] wrap_add(input logic [7:0] pos,
                                          input logic [7:0] offs,
                                          input logic [8:0] lim);
    logic [8:0] red;
    logic [8:0] sum;
    red = ({1'b0, offs} >= lim) ? ({1'b0, offs} - lim) : {1'b0, offs};
    sum = {1'b0, pos} + red;
    if (sum >= lim) sum = sum - lim;
    return 8'(sum);
  endfunction

endpackage

// File: rtl/text_layer_font_rom.sv
// 8x8 glyph ROM, address {char, row}, registered one-cycle read.
// Sparse glyph set: undefined characters are blank.
module font_rom (
  input  logic        i_clk,
  input  logic [10:0] i_addr,
  output logic [7:0]  o_data
);

  function automatic logic [7:0] glyph(input logic [10:0] a);
    logic [7:0] g;
    g = '0;
    if (a[10:3] == 8'hFF) begin
      g = '1;
    end else begin
      case (a)
        11'h208: g = 8'h18;
        11'h209: g = 8'h3C;
        11'h20A: g = 8'h66;
        11'h20B: g = 8'h66;
        11'h20C: g = 8'h7E;
        11'h20D: g = 8'h66;
        11'h20E: g = 8'h66;
        default: g = '0;
      endcase
    end
    return g;
  endfunction

  always_ff @(posedge i_clk) begin
    o_data <= glyph(i_addr);
  end

endmodule

// File: rtl/text_layer.sv
// Character-cell text layer: CPU-mapped char/attr RAM, scroll registers and a
// 3-stage pixel pipeline. Optional blinking cursor when CURSOR_EN is defined.
module text_layer
  import text_pkg::*;
#(
  parameter  int unsigned COLS         = 20,
  parameter  int unsigned ROWS         = 15,
  parameter  int unsigned BLINK_FRAMES = 16,
  localparam int unsigned AW           = $clog2(2*COLS*ROWS+4)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          oe,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    di,
  output logic [7:0]    dout,
  input  logic [7:0]    hpos,
  input  logic [7:0]    vpos,
  input  logic          hsync,
  input  logic          vsync,
  output logic [3:0]    color
);

  localparam int unsigned N      = COLS*ROWS;
  localparam int unsigned CW     = $clog2(N);
  localparam logic [8:0]  LIM_X  = 9'(COLS*8);
  localparam logic [8:0]  LIM_Y  = 9'(ROWS*8);
  localparam logic [AW-1:0] A_ATTR = AW'(N);
  localparam logic [AW-1:0] A_REG  = AW'(2*N);

  logic [7:0] r_char_mem [N];
  logic [7:0] r_attr_mem [N];
  logic [7:0] r_scroll_x, r_scroll_y;

  sel_t          w_sel;
  logic [CW-1:0] w_cpu_idx;
  logic [7:0]    w_rd_data;

  always_comb begin
    w_sel     = SEL_NONE;
    w_cpu_idx = '0;
    if (addr < A_ATTR) begin
      w_sel     = SEL_CHAR;
      w_cpu_idx = CW'(addr);
    end else if (addr < A_REG) begin
      w_sel     = SEL_ATTR;
      w_cpu_idx = CW'(addr - A_ATTR);
    end else if (addr == A_REG + AW'(OFS_SCROLL_X)) begin
      w_sel = SEL_SCROLL_X;
    end else if (addr == A_REG + AW'(OFS_SCROLL_Y)) begin
      w_sel = SEL_SCROLL_Y;
    end else if (addr == A_REG + AW'(OFS_CURSOR_COL)) begin
      w_sel = SEL_CURSOR_COL;
    end else if (addr == A_REG + AW'(OFS_CURSOR_ROW)) begin
      w_sel = SEL_CURSOR_ROW;
    end
  end

`ifdef CURSOR_EN
  logic [7:0] r_cursor_col, r_cursor_row;
  logic [7:0] r_frame_cnt;
  logic [$clog2(BLINK_FRAMES+1)-1:0] r_blink_cnt;
  logic r_blink_phase, r_vsync_d;
  logic w_unused_frame;
  assign w_unused_frame = ^r_frame_cnt;
`endif

  always_comb begin
    w_rd_data = '0;
    case (w_sel)
      SEL_CHAR:       w_rd_data = r_char_mem[w_cpu_idx];
      SEL_ATTR:       w_rd_data = r_attr_mem[w_cpu_idx];
      SEL_SCROLL_X:   w_rd_data = r_scroll_x;
      SEL_SCROLL_Y:   w_rd_data = r_scroll_y;
`ifdef CURSOR_EN
      SEL_CURSOR_COL: w_rd_data = r_cursor_col;
      SEL_CURSOR_ROW: w_rd_data = r_cursor_row;
`endif
      default:        w_rd_data = '0;
    endcase
  end

  // Non-blocking RAM write: same-cycle readers (CPU and pixel path) see old data
  always_ff @(posedge clk) begin
    if (we && w_sel == SEL_CHAR) r_char_mem[w_cpu_idx] <= di;
    if (we && w_sel == SEL_ATTR) r_attr_mem[w_cpu_idx] <= di;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= '0;
      r_scroll_x <= '0;
      r_scroll_y <= '0;
`ifdef CURSOR_EN
      r_cursor_col <= '0;
      r_cursor_row <= '0;
`endif
    end else begin
      if (oe) dout <= w_rd_data;
      if (we) begin
        case (w_sel)
          SEL_SCROLL_X:   r_scroll_x   <= di;
          SEL_SCROLL_Y:   r_scroll_y   <= di;
`ifdef CURSOR_EN
          SEL_CURSOR_COL: r_cursor_col <= di;
          SEL_CURSOR_ROW: r_cursor_row <= di;
`endif
          default: ;
        endcase
      end
    end
  end

`ifdef CURSOR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vsync_d     <= 1'b0;
      r_frame_cnt   <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      if (vsync && !r_vsync_d) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        if (r_blink_cnt == ($clog2(BLINK_FRAMES+1))'(BLINK_FRAMES-1)) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end
`endif

  logic [7:0]    w_x, w_y;
  logic [CW-1:0] w_cell;
  logic          w_cur_hit;

  assign w_x    = wrap_add(hpos, r_scroll_x, LIM_X);
  assign w_y    = wrap_add(vpos, r_scroll_y, LIM_Y);
  assign w_cell = CW'(32'(w_y[7:3]) * COLS + 32'(w_x[7:3]));

`ifdef CURSOR_EN
  assign w_cur_hit = r_blink_phase &&
                     ({3'b000, hpos[7:3]} == r_cursor_col) &&
                     ({3'b000, vpos[7:3]} == r_cursor_row);
`else
  assign w_cur_hit = 1'b0;
`endif

  logic [7:0] r_s1_char, r_s1_attr, r_s2_attr;
  logic [2:0] r_s1_px, r_s1_py, r_s2_px;
  logic       r_s1_sync, r_s2_sync, r_s1_cur, r_s2_cur;
  logic [7:0] w_glyph;
  attr_t      w_a_raw, w_attr;

  font_rom u_font_rom (
    .i_clk  (clk),
    .i_addr ({r_s1_char, r_s1_py}),
    .o_data (w_glyph)
  );

  assign w_a_raw = attr_t'(r_s2_attr);
  assign w_attr  = r_s2_cur ? '{bg: w_a_raw.fg, fg: w_a_raw.bg} : w_a_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_char <= '0;
      r_s1_attr <= '0;
      r_s1_px   <= '0;
      r_s1_py   <= '0;
      r_s1_sync <= 1'b0;
      r_s1_cur  <= 1'b0;
      r_s2_attr <= '0;
      r_s2_px   <= '0;
      r_s2_sync <= 1'b0;
      r_s2_cur  <= 1'b0;
      color     <= '0;
    end else begin
      r_s1_char <= r_char_mem[w_cell];
      r_s1_attr <= r_attr_mem[w_cell];
      r_s1_px   <= w_x[2:0];
      r_s1_py   <= w_y[2:0];
      r_s1_sync <= hsync | vsync;
      r_s1_cur  <= w_cur_hit;
      r_s2_attr <= r_s1_attr;
      r_s2_px   <= r_s1_px;
      r_s2_sync <= r_s1_sync;
      r_s2_cur  <= r_s1_cur;
      if (r_s2_sync)               color <= '0;
      else if (w_glyph[~r_s2_px])  color <= w_attr.fg;
      else                         color <= w_attr.bg;
    end
  end

endmodule

// File: tb/tb_text_layer.sv
// Directed bench for text_layer (COLS=20, ROWS=15, BLINK_FRAMES=2).
// Cursor blink steps are exercised when built with CURSOR_EN.
module tb_text_layer;

  localparam int unsigned COLS = 20;
  localparam int unsigned ROWS = 15;
  localparam int unsigned AW   = 10;
  localparam int A_SX = 600;
  localparam int A_SY = 601;
  localparam int A_CC = 602;

  logic          clk = 1'b0;
  logic          reset, we, oe, hsync, vsync;
  logic [AW-1:0] addr;
  logic [7:0]    di, dout, hpos, vpos;
  logic [3:0]    color;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  text_layer #(.COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .oe    (oe),
    .addr  (addr),
    .di    (di),
    .dout  (dout),
    .hpos  (hpos),
    .vpos  (vpos),
    .hsync (hsync),
    .vsync (vsync),
    .color (color)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic cpu_wr(input int a, input logic [7:0] d);
    addr = AW'(a);
    di   = d;
    we   = 1'b1;
    step();
    we   = 1'b0;
  endtask

  task automatic cpu_rd(input int a, output logic [7:0] d);
    addr = AW'(a);
    oe   = 1'b1;
    step();
    oe   = 1'b0;
    d    = dout;
  endtask

  task automatic pix(input logic [7:0] h, input logic [7:0] v, output logic [3:0] c);
    hpos = h;
    vpos = v;
    repeat (3) step();
    c = color;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
  endtask

  logic [7:0] rd;
  logic [3:0] c;
  logic [3:0] exp_a [8] = '{4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'h1, 4'h1, 4'h1};

  initial begin
    reset = 1'b0; we = 1'b0; oe = 1'b0; addr = '0; di = '0;
    hpos = '0; vpos = '0; hsync = 1'b0; vsync = 1'b0;
    #12;
    check8("reset_color", {4'h0, color}, 8'h00);
    check8("reset_dout", dout, 8'h00);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check8("post_rst_c0", {4'h0, color}, 8'h00);
    step();
    check8("post_rst_c1", {4'h0, color}, 8'h00);
    step();
    check8("post_rst_c2", {4'h0, color}, 8'h00);

    cpu_wr(0, 8'h41);
    cpu_wr(300, 8'h1F);
    cpu_wr(20, 8'hFF);
    cpu_wr(320, 8'h5A);
    cpu_wr(1, 8'hFF);
    cpu_wr(301, 8'h4C);
    cpu_wr(5, 8'h20);
    cpu_wr(305, 8'h96);

    cpu_rd(0, rd);
    check8("rd_char0", rd, 8'h41);
    cpu_rd(300, rd);
    check8("rd_attr0", rd, 8'h1F);
    addr = AW'(0);
    step();
    check8("dout_hold", dout, 8'h1F);

    // Back-to-back pixels across glyph 'A' row 0 (0x18)
    for (int i = 0; i < 10; i++) begin
      hpos = (i < 8) ? 8'(i) : 8'h00;
      vpos = 8'h00;
      step();
      if (i >= 2) check8($sformatf("stream_x%0d", i - 2), {4'h0, color}, {4'h0, exp_a[i-2]});
    end

    cpu_wr(A_SX, 8'd8);
    pix(8'd152, 8'd0, c);
    check8("wrap_x152", {4'h0, c}, 8'h01);
    pix(8'd155, 8'd0, c);
    check8("wrap_x155", {4'h0, c}, 8'h0F);

    cpu_wr(A_SX, 8'd200);
    cpu_rd(A_SX, rd);
    check8("rd_scroll_x", rd, 8'd200);
    pix(8'd130, 8'd0, c);
    check8("sx200_h130", {4'h0, c}, 8'h0C);
    pix(8'd3, 8'd0, c);
    check8("sx200_h3", {4'h0, c}, 8'h09);

    addr = AW'(5); di = 8'hAA; we = 1'b1; oe = 1'b1;
    step();
    we = 1'b0; oe = 1'b0;
    check8("rbw_old", dout, 8'h20);
    cpu_rd(5, rd);
    check8("rbw_new", rd, 8'hAA);

    cpu_wr(700, 8'h55);
    cpu_rd(700, rd);
    check8("rd_oob", rd, 8'h00);
`ifndef CURSOR_EN
    cpu_wr(A_CC, 8'h03);
    cpu_rd(A_CC, rd);
    check8("rd_cursor_off", rd, 8'h00);
`endif

    cpu_wr(A_SX, 8'd0);
    cpu_wr(A_SY, 8'd8);
    pix(8'd3, 8'd112, c);
    check8("wrap_y", {4'h0, c}, 8'h0F);
    cpu_wr(A_SY, 8'd0);

    pix(8'd3, 8'd0, c);
    check8("pre_sync", {4'h0, c}, 8'h0F);
    hsync = 1'b1;
    step();
    check8("sync_delay", {4'h0, color}, 8'h0F);
    step();
    step();
    check8("hsync_blank", {4'h0, color}, 8'h00);
    hsync = 1'b0;

`ifdef CURSOR_EN
    vs_pulse();
    pix(8'd3, 8'd0, c);
    check8("cur_edge1", {4'h0, c}, 8'h0F);
    vs_pulse();
    pix(8'd3, 8'd0, c);
    check8("cur_edge2", {4'h0, c}, 8'h01);
    vs_pulse();
    pix(8'd3, 8'd0, c);
    check8("cur_edge3", {4'h0, c}, 8'h01);
    vs_pulse();
    pix(8'd3, 8'd0, c);
    check8("cur_edge4", {4'h0, c}, 8'h0F);
`endif

    cpu_wr(A_SX, 8'd8);
    cpu_rd(0, rd);
    check8("pre_rst_dout", rd, 8'h41);
    pix(8'd155, 8'd0, c);
    check8("pre_rst_color", {4'h0, c}, 8'h0F);
    #3;
    reset = 1'b0;
    #1;
    check8("mid_rst_color", {4'h0, color}, 8'h00);
    check8("mid_rst_dout", dout, 8'h00);
    #2;
    reset = 1'b1;
    cpu_rd(A_SX, rd);
    check8("mid_rst_sx", rd, 8'h00);
    cpu_rd(300, rd);
    check8("ram_keep", rd, 8'h1F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
